calc_ctrl: RTL and testbench

Sequencing controller for the keypad calculator. Sits between `keyboard` (`press`/`scan_code`, sampled on the divided `clk_key` domain) and the `bin2bcd` → seven-segment path. It debounces key events, runs the operand/operator/result state machine and drives the 8-bit binary value to display. It replaces the free-running accumulator in the display path with two-operand add, subtract and multiply.

---
 rtl/calc_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_calc_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad calculator sequencer. Debounces key events, runs the
// operand/operator/result FSM and registers the value shown on the display.
module calc_ctrl #(
  parameter int unsigned DEB = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       press,
  input  logic [3:0] scan_code,
  output logic [7:0] disp_val,
  output logic       err,
  output logic [1:0] op_sel,
  output logic [2:0] state,
  output logic       key_ack
);

  typedef enum logic [2:0] {
    StOpa = 3'd0,
    StOp  = 3'd1,
    StOpb = 3'd2,
    StRes = 3'd3,
    StErr = 3'd4
  } state_e;

  localparam logic [3:0] KeyClr   = 4'hD;
  localparam logic [3:0] KeyEq    = 4'hE;
  localparam logic [3:0] KeyClrE  = 4'hF;
  localparam logic [1:0] OpNone   = 2'd3;

  logic [3:0] r_cnt;
  logic       r_armed;
  state_e     r_state;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [1:0] r_op;
  logic [7:0] r_disp;
  logic       r_err;
  logic       r_ack;

  logic        w_cnt_hit;
  logic        w_evt;
  logic        w_is_dig;
  logic        w_is_op;
  logic [1:0]  w_key_op;
  logic [11:0] w_app_a;
  logic [11:0] w_app_b;
  logic [8:0]  w_sum;
  logic [15:0] w_prod;
  logic [7:0]  w_f_res;
  logic        w_f_err;
  state_e      w_state_n;
  logic [7:0]  w_a_n;
  logic [7:0]  w_b_n;
  logic [1:0]  w_op_n;

  // The counter reaching DEB-1 means this sample is the DEB-th in a row.
  assign w_cnt_hit = (r_cnt == 4'(DEB - 1));
  assign w_evt     = r_armed & press & w_cnt_hit;

  assign w_is_dig  = (scan_code <= 4'd9);
  assign w_is_op   = (scan_code >= 4'hA) && (scan_code <= 4'hC);
  assign w_key_op  = 2'(scan_code - 4'hA);

  // 12 bits covers 255*10+9 without wrap.
  assign w_app_a   = 12'(r_a) * 12'd10 + 12'(scan_code);
  assign w_app_b   = 12'(r_b) * 12'd10 + 12'(scan_code);
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_prod    = 16'(r_a) * 16'(r_b);

  // Binary operation result and its overflow/underflow flag.
  always_comb begin
    w_f_res = r_a;
    w_f_err = 1'b0;
    unique case (r_op)
      2'd0: begin
        w_f_res = w_sum[7:0];
        w_f_err = w_sum[8];
      end
      2'd1: begin
        w_f_res = r_a - r_b;
        w_f_err = (r_b > r_a);
      end
      2'd2: begin
        w_f_res = w_prod[7:0];
        w_f_err = (w_prod > 16'd255);
      end
      default: begin
        w_f_res = r_a;
        w_f_err = 1'b0;
      end
    endcase
  end

  // Next FSM state and operand registers for an accepted key.
  always_comb begin
    w_state_n = r_state;
    w_a_n     = r_a;
    w_b_n     = r_b;
    w_op_n    = r_op;
    if (w_evt) begin
      if (scan_code == KeyClr) begin
        w_state_n = StOpa;
        w_a_n     = 8'd0;
        w_b_n     = 8'd0;
        w_op_n    = OpNone;
      end else begin
        case (r_state)
          StOpa: begin
            if (w_is_dig) begin
              if (w_app_a <= 12'd255) w_a_n = w_app_a[7:0];
            end else if (w_is_op) begin
              w_op_n    = w_key_op;
              w_state_n = StOp;
            end else if (scan_code == KeyClrE) begin
              w_a_n = 8'd0;
            end
          end
          StOp: begin
            if (w_is_dig) begin
              w_b_n     = 8'(scan_code);
              w_state_n = StOpb;
            end else if (w_is_op) begin
              w_op_n = w_key_op;
            end
          end
          StOpb: begin
            if (w_is_dig) begin
              if (w_app_b <= 12'd255) w_b_n = w_app_b[7:0];
            end else if (scan_code == KeyClrE) begin
              w_b_n = 8'd0;
            end else if (w_f_err) begin
              // Equals or a chained operator that overflows.
              w_state_n = StErr;
              w_a_n     = 8'd0;
              w_b_n     = 8'd0;
              w_op_n    = OpNone;
            end else if (scan_code == KeyEq) begin
              w_a_n     = w_f_res;
              w_op_n    = OpNone;
              w_state_n = StRes;
            end else begin
              w_a_n     = w_f_res;
              w_op_n    = w_key_op;
              w_state_n = StOp;
            end
          end
          StRes: begin
            if (w_is_dig) begin
              w_a_n     = 8'(scan_code);
              w_state_n = StOpa;
            end else if (w_is_op) begin
              w_op_n    = w_key_op;
              w_state_n = StOp;
            end else if (scan_code == KeyClrE) begin
              w_a_n     = 8'd0;
              w_state_n = StOpa;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Debounce, FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= 4'd0;
      r_armed <= 1'b1;
      r_state <= StOpa;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_op    <= OpNone;
      r_disp  <= 8'd0;
      r_err   <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      if (r_armed) begin
        if (!press) begin
          r_cnt <= 4'd0;
        end else if (w_cnt_hit) begin
          r_cnt   <= 4'd0;
          r_armed <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else begin
        if (press) begin
          r_cnt <= 4'd0;
        end else if (w_cnt_hit) begin
          r_cnt   <= 4'd0;
          r_armed <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
      r_ack   <= w_evt;
      r_state <= w_state_n;
      r_a     <= w_a_n;
      r_b     <= w_b_n;
      r_op    <= w_op_n;
      r_err   <= (w_state_n == StErr);
      if (w_state_n == StOpb)      r_disp <= w_b_n;
      else if (w_state_n == StErr) r_disp <= 8'd0;
      else                         r_disp <= w_a_n;
    end
  end

  assign disp_val = r_disp;
  assign err      = r_err;
  assign op_sel   = r_op;
  assign state    = r_state;
  assign key_ack  = r_ack;

endmodule

// File: tb/tb_calc_ctrl.sv
// Bench for calc_ctrl: table of keystrokes with expected display, directed
// debounce/reset corners, and random keystrokes against a behavioural model.
module tb_calc_ctrl;

  localparam int DEB = 2;

  logic       clk;
  logic       rst;
  logic       press;
  logic [3:0] scan_code;
  logic [7:0] disp_val;
  logic       err;
  logic [1:0] op_sel;
  logic [2:0] state;
  logic       key_ack;

  calc_ctrl #(.DEB(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .press    (press),
    .scan_code(scan_code),
    .disp_val (disp_val),
    .err      (err),
    .op_sel   (op_sel),
    .state    (state),
    .key_ack  (key_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural calculator model: plain integers.
  int m_a, m_b, m_op, m_st;

  task automatic model_reset();
    m_a = 0; m_b = 0; m_op = 3; m_st = 0;
  endtask

  task automatic model_key(input int code);
    int r;
    bit dig, opk;
    dig = (code < 10);
    opk = (code >= 10) && (code <= 12);
    if (code == 13) begin
      model_reset();
      return;
    end
    case (m_st)
      0: begin
        if (dig) begin
          if (m_a * 10 + code <= 255) m_a = m_a * 10 + code;
        end else if (opk) begin
          m_op = code - 10; m_st = 1;
        end else if (code == 15) m_a = 0;
      end
      1: begin
        if (dig) begin
          m_b = code; m_st = 2;
        end else if (opk) m_op = code - 10;
      end
      2: begin
        if (dig) begin
          if (m_b * 10 + code <= 255) m_b = m_b * 10 + code;
        end else if (code == 15) begin
          m_b = 0;
        end else begin
          r = (m_op == 0) ? m_a + m_b : (m_op == 1) ? m_a - m_b : m_a * m_b;
          if (r < 0 || r > 255) begin
            m_a = 0; m_b = 0; m_op = 3; m_st = 4;
          end else begin
            m_a = r;
            if (code == 14) begin
              m_op = 3; m_st = 3;
            end else begin
              m_op = code - 10; m_st = 1;
            end
          end
        end
      end
      3: begin
        if (dig) begin
          m_a = code; m_st = 0;
        end else if (opk) begin
          m_op = code - 10; m_st = 1;
        end else if (code == 15) begin
          m_a = 0; m_st = 0;
        end
      end
      default: ;
    endcase
  endtask

  function automatic int model_disp();
    if (m_st == 2) return m_b;
    if (m_st == 4) return 0;
    return m_a;
  endfunction

  task automatic chk(input string name, input bit exp_ack);
    logic [14:0] got, exp;
    got = {disp_val, err, op_sel, state, key_ack};
    exp = {8'(model_disp()), (m_st == 4), 2'(m_op), 3'(m_st), exp_ack};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got disp=%0d err=%0d op=%0d st=%0d ack=%0d, want disp=%0d err=%0d op=%0d st=%0d ack=%0d",
               name, disp_val, err, op_sel, state, key_ack,
               exp[14:7], exp[6], exp[5:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Well-formed key press: hold >= DEB, release >= DEB. Scan code is
  // scrambled after the accepting edge to prove it is latched only there.
  task automatic press_key(input int code, input int hold, input int rel);
    press = 1'b1;
    scan_code = 4'(code);
    for (int i = 0; i < hold; i++) begin
      step();
      if (i == DEB - 1) model_key(code);
      chk("hold", (i == DEB - 1));
      if (i >= DEB - 1) scan_code = 4'($urandom_range(0, 15));
    end
    press = 1'b0;
    for (int i = 0; i < rel; i++) begin
      scan_code = 4'($urandom_range(0, 15));
      step();
      chk("release", 1'b0);
    end
  endtask

  typedef struct {
    int         key;
    logic [7:0] disp;
    logic [2:0] st;
    logic [1:0] op;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int k, input int d, input int s, input int o, input int e);
    vec_t v;
    v.key = k; v.disp = 8'(d); v.st = 3'(s); v.op = 2'(o); v.err = e[0];
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b0;
    press = 1'b1;
    scan_code = 4'd5;
    model_reset();

    // Reset with press held high.
    step();
    chk("reset0", 1'b0);
    step();
    chk("reset1", 1'b0);
    press = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset", 1'b0);
    end

    // Add: 1,2,A,3,0,E
    add(1, 1, 0, 3, 0);   add(2, 12, 0, 3, 0);  add(10, 12, 1, 0, 0);
    add(3, 3, 2, 0, 0);   add(0, 30, 2, 0, 0);  add(14, 42, 3, 3, 0);
    add(13, 0, 0, 3, 0);
    // Chained: 9,C,9,B,1,E
    add(9, 9, 0, 3, 0);   add(12, 9, 1, 2, 0);  add(9, 9, 2, 2, 0);
    add(11, 81, 1, 1, 0); add(1, 1, 2, 1, 0);   add(14, 80, 3, 3, 0);
    add(13, 0, 0, 3, 0);
    // Add overflow, ignored key in ERR, clear.
    add(2, 2, 0, 3, 0);   add(0, 20, 0, 3, 0);  add(0, 200, 0, 3, 0);
    add(10, 200, 1, 0, 0); add(1, 1, 2, 0, 0);  add(0, 10, 2, 0, 0);
    add(0, 100, 2, 0, 0); add(14, 0, 4, 3, 1);  add(5, 0, 4, 3, 1);
    add(13, 0, 0, 3, 0);
    // Sub underflow.
    add(3, 3, 0, 3, 0);   add(11, 3, 1, 1, 0);  add(4, 4, 2, 1, 0);
    add(14, 0, 4, 3, 1);  add(13, 0, 0, 3, 0);
    // Entry saturation and clear entry.
    add(2, 2, 0, 3, 0);   add(5, 25, 0, 3, 0);  add(6, 25, 0, 3, 0);
    add(13, 0, 0, 3, 0);
    add(2, 2, 0, 3, 0);   add(5, 25, 0, 3, 0);  add(5, 255, 0, 3, 0);
    add(15, 0, 0, 3, 0);
    // Result reuse and RES transitions.
    add(7, 7, 0, 3, 0);   add(10, 7, 1, 0, 0);  add(8, 8, 2, 0, 0);
    add(14, 15, 3, 3, 0); add(12, 15, 1, 2, 0); add(2, 2, 2, 2, 0);
    add(15, 0, 2, 2, 0);  add(3, 3, 2, 2, 0);   add(14, 45, 3, 3, 0);
    add(15, 0, 0, 3, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      logic [13:0] got, exp;
      press_key(tbl[i].key, 3, 3);
      got = {disp_val, err, op_sel, state};
      exp = {tbl[i].disp, tbl[i].err, tbl[i].op, tbl[i].st};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL table[%0d] key=%0d: got disp=%0d err=%0d op=%0d st=%0d, want disp=%0d err=%0d op=%0d st=%0d",
                 i, tbl[i].key, disp_val, err, op_sel, state,
                 tbl[i].disp, tbl[i].err, tbl[i].op, tbl[i].st);
      end
    end

    // Debounce: single-sample glitch must not produce an event.
    press_key(13, 3, 3);
    press = 1'b1;
    scan_code = 4'd7;
    step();
    chk("glitch_hi", 1'b0);
    press = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("glitch_lo", 1'b0);
    end

    // Key 7 held 20 cycles -> one event; then a 1-cycle release does not re-arm.
    press_key(7, 20, 1);
    press = 1'b1;
    scan_code = 4'd7;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no_rearm_hi", 1'b0);
    end
    press = 1'b0;
    for (int i = 0; i < DEB; i++) begin
      step();
      chk("rearm_lo", 1'b0);
    end
    press_key(7, 3, 3);
    n_vec++;
    if (disp_val !== 8'd77) begin
      n_err++;
      $display("FAIL rearm_value: got disp=%0d want 77", disp_val);
    end

    // Reset wins over an event on the same edge.
    press = 1'b1;
    scan_code = 4'd4;
    step();
    chk("pre_rst_event", 1'b0);
    rst = 1'b0;
    step();
    model_reset();
    chk("rst_over_event", 1'b0);
    rst = 1'b1;
    press = 1'b0;
    for (int i = 0; i < DEB; i++) begin
      step();
      chk("rst_release", 1'b0);
    end

    // Random well-formed keystrokes against the model.
    for (int n = 0; n < 300; n++) begin
      int r, code;
      r = $urandom_range(0, 99);
      if (r < 55)      code = $urandom_range(0, 9);
      else if (r < 80) code = $urandom_range(10, 12);
      else if (r < 88) code = 14;
      else if (r < 95) code = 15;
      else             code = 13;
      press_key(code, DEB + $urandom_range(0, 3), DEB + $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
